// File: rtl/clks_alot_monitor.sv
// Clock-recovery front end: samples the synchronised IO clock, emits one-hot edge events,
// measures half-periods and pauses. Optional CLKS_ALOT_MONITOR_GLITCH_FILTER_EN adds a 3-sample input filter.
module clks_alot_monitor #(
    parameter int COUNTER_WIDTH                       = 32,
    parameter int SYS_CLOCK_MULTIPLE                  = 64,
    parameter int CLOCK_EDGE_UNCERTANTY               = 1,
    parameter int MINIMUM_MISSED_EDGES_TO_START_PAUSE = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     io_clk_i,
    input  logic                     clear_violations_i,
    output logic [3:0]               events_o,
    output logic [COUNTER_WIDTH+4:0] status_o
);

    localparam int W      = COUNTER_WIDTH;
    localparam int TICK_W = $clog2(SYS_CLOCK_MULTIPLE + 1);

    localparam logic [W-1:0]      MIN_HALF           = W'(SYS_CLOCK_MULTIPLE / 2 - CLOCK_EDGE_UNCERTANTY);
    localparam logic [W-1:0]      MAX_HALF           = W'(SYS_CLOCK_MULTIPLE / 2 + CLOCK_EDGE_UNCERTANTY);
    localparam logic [W:0]        MIN_PERIOD         = (W+1)'(2 * (SYS_CLOCK_MULTIPLE / 2 - CLOCK_EDGE_UNCERTANTY));
    localparam logic [W:0]        MAX_PERIOD         = (W+1)'(2 * (SYS_CLOCK_MULTIPLE / 2 + CLOCK_EDGE_UNCERTANTY));
    localparam logic [W-1:0]      PAUSE_START_LENGTH = W'(MINIMUM_MISSED_EDGES_TO_START_PAUSE * SYS_CLOCK_MULTIPLE);
    localparam logic [W-1:0]      PAUSE_INIT         = W'(MINIMUM_MISSED_EDGES_TO_START_PAUSE);
    localparam logic [W-1:0]      CNT_MAX            = {W{1'b1}};
    localparam logic [TICK_W-1:0] TICK_LAST          = TICK_W'(SYS_CLOCK_MULTIPLE);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, RECOVER} state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q;
    logic [3:0]          events_q, events_d;
    logic [W-1:0]        halfCnt_q, halfCnt_d;
    logic [W-1:0]        firstHalf_q, firstHalf_d;
    logic                secondHalf_q, secondHalf_d;
    logic [TICK_W-1:0]   pauseTick_q, pauseTick_d;
    logic                pauseActive_q, pauseActive_d;
    logic [W-1:0]        pauseDuration_q, pauseDuration_d;
    logic                maxFreq_q, minFreq_q, recUnder_q, recOver_q;
    logic                maxFreq_d, minFreq_d, recUnder_d, recOver_d;
    logic                setMaxFreq, setMinFreq, setRecUnder, setRecOver;
    logic                edgeSeen, risingEdge, fallingEdge, pauseStart;
    logic [W:0]          period;

`ifdef CLKS_ALOT_MONITOR_GLITCH_FILTER_EN
    logic raw0_q, raw1_q;

    // The first sync stage only follows io_clk_i once three consecutive samples agree.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            raw0_q  <= 1'b0;
            raw1_q  <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            raw0_q <= io_clk_i;
            raw1_q <= raw0_q;
            if ((io_clk_i == raw0_q) && (raw0_q == raw1_q)) begin
                sync1_q <= io_clk_i;
            end
        end
    end
`else
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= 1'b0;
        end else begin
            sync1_q <= io_clk_i;
        end
    end
`endif

    assign edgeSeen    = sync1_q ^ sync2_q;
    assign risingEdge  = sync1_q & ~sync2_q;
    assign fallingEdge = ~sync1_q & sync2_q;
    assign pauseStart  = (halfCnt_q == PAUSE_START_LENGTH) && !edgeSeen;
    assign period      = {1'b0, firstHalf_q} + {1'b0, halfCnt_q};

    always_comb begin
        events_d = 4'b0001;
        if (risingEdge) begin
            events_d = 4'b1000;
        end else if (fallingEdge) begin
            events_d = 4'b0010;
        end else if (sync1_q) begin
            events_d = 4'b0100;
        end

        halfCnt_d = halfCnt_q;
        if (edgeSeen) begin
            halfCnt_d = W'(1);
        end else if (halfCnt_q != CNT_MAX) begin
            halfCnt_d = halfCnt_q + W'(1);
        end
    end

    // FSM: frequency checks in RUN, full-period check in RECOVER, pause timing in PAUSE.
    always_comb begin
        state_d         = state_q;
        firstHalf_d     = firstHalf_q;
        secondHalf_d    = secondHalf_q;
        pauseTick_d     = pauseTick_q;
        pauseActive_d   = pauseActive_q;
        pauseDuration_d = pauseDuration_q;
        setMaxFreq      = 1'b0;
        setMinFreq      = 1'b0;
        setRecUnder     = 1'b0;
        setRecOver      = 1'b0;

        case (state_q)
            IDLE: begin
                if (edgeSeen) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (edgeSeen) begin
                    setMaxFreq = (halfCnt_q < MIN_HALF);
                    setMinFreq = (halfCnt_q > MAX_HALF);
                end
            end
            RECOVER: begin
                if (edgeSeen) begin
                    if (!secondHalf_q) begin
                        firstHalf_d  = halfCnt_q;
                        secondHalf_d = 1'b1;
                    end else begin
                        setRecUnder = (period < MIN_PERIOD);
                        setRecOver  = (period > MAX_PERIOD);
                        state_d     = RUN;
                    end
                end
            end
            PAUSE: begin
                if (edgeSeen) begin
                    pauseActive_d = 1'b0;
                    secondHalf_d  = 1'b0;
                    state_d       = RECOVER;
                end else if (pauseTick_q == TICK_LAST) begin
                    pauseTick_d = TICK_W'(1);
                    if (pauseDuration_q != CNT_MAX) begin
                        pauseDuration_d = pauseDuration_q + W'(1);
                    end
                end else begin
                    pauseTick_d = pauseTick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != PAUSE) && pauseStart) begin
            state_d         = PAUSE;
            pauseActive_d   = 1'b1;
            pauseDuration_d = PAUSE_INIT;
            pauseTick_d     = TICK_W'(1);
        end
    end

    // A set in the same cycle as a clear keeps the flag set.
    always_comb begin
        maxFreq_d  = setMaxFreq  | (maxFreq_q  & ~clear_violations_i);
        minFreq_d  = setMinFreq  | (minFreq_q  & ~clear_violations_i);
        recUnder_d = setRecUnder | (recUnder_q & ~clear_violations_i);
        recOver_d  = setRecOver  | (recOver_q  & ~clear_violations_i);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync2_q         <= 1'b0;
            events_q        <= 4'b0001;
            halfCnt_q       <= '0;
            state_q         <= IDLE;
            firstHalf_q     <= '0;
            secondHalf_q    <= 1'b0;
            pauseTick_q     <= '0;
            pauseActive_q   <= 1'b0;
            pauseDuration_q <= '0;
            maxFreq_q       <= 1'b0;
            minFreq_q       <= 1'b0;
            recUnder_q      <= 1'b0;
            recOver_q       <= 1'b0;
        end else begin
            sync2_q         <= sync1_q;
            events_q        <= events_d;
            halfCnt_q       <= halfCnt_d;
            state_q         <= state_d;
            firstHalf_q     <= firstHalf_d;
            secondHalf_q    <= secondHalf_d;
            pauseTick_q     <= pauseTick_d;
            pauseActive_q   <= pauseActive_d;
            pauseDuration_q <= pauseDuration_d;
            maxFreq_q       <= maxFreq_d;
            minFreq_q       <= minFreq_d;
            recUnder_q      <= recUnder_d;
            recOver_q       <= recOver_d;
        end
    end

    assign events_o = events_q;
    assign status_o = {recOver_q, recUnder_q, minFreq_q, maxFreq_q, pauseActive_q, pauseDuration_q};

endmodule

// File: tb/tb_clks_alot_monitor.sv
// Directed self-checking bench for clks_alot_monitor at default parameters
// (MIN_HALF=31, MAX_HALF=33, pause threshold 256 sys cycles).
module tb_clks_alot_monitor;

    localparam int W = 32;

    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         io_clk_i;
    logic         clear_violations_i;
    logic [3:0]   events_o;
    logic [W+4:0] status_o;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    clks_alot_monitor #(
        .COUNTER_WIDTH                      (W),
        .SYS_CLOCK_MULTIPLE                 (64),
        .CLOCK_EDGE_UNCERTANTY              (1),
        .MINIMUM_MISSED_EDGES_TO_START_PAUSE(4)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .io_clk_i          (io_clk_i),
        .clear_violations_i(clear_violations_i),
        .events_o          (events_o),
        .status_o          (status_o)
    );

    // Inputs change just after a falling edge, so each call covers n samples at lvl.
    task automatic holdLevel(input logic lvl, input int n);
        io_clk_i = lvl;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst            = 1'b1;
        io_clk_i           = 1'b0;
        clear_violations_i = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if (events_o !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_events: got %b expected %b", events_o, 4'b0001);
        end
        checks++;
        if (status_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_status: got %h expected %h", status_o, {(W+5){1'b0}});
        end
        sys_rst = 1'b0;
    endtask

    // Every cycle: events must reflect the io samples from two and three cycles ago.
    task automatic test_clock_events();
        logic h0, h1, h2;
        logic [3:0] expEv;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
        for (int p = 0; p < 10; p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                io_clk_i = (ph == 0);
                for (int c = 0; c < 32; c++) begin
                    @(negedge sys_clk);
                    h2 = h1; h1 = h0; h0 = io_clk_i;
                    if (h1 && !h2)      expEv = 4'b1000;
                    else if (!h1 && h2) expEv = 4'b0010;
                    else if (h1)        expEv = 4'b0100;
                    else                expEv = 4'b0001;
                    checks++;
                    if (events_o !== expEv) begin
                        errors++;
                        $display("[TB] FAIL events_p%0d_c%0d: got %b expected %b", p, ph * 32 + c, events_o, expEv);
                    end
                    checks++;
                    if (status_o !== '0) begin
                        errors++;
                        $display("[TB] FAIL status_steady_p%0d: got %h expected 0", p, status_o);
                    end
                end
            end
        end
    endtask

    task automatic test_max_freq();
        holdLevel(1'b1, 30);
        io_clk_i = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (status_o[W+1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL max_freq_early: got %b expected 0", status_o[W+1]);
        end
        @(negedge sys_clk);
        checks++;
        if (status_o !== {5'b00010, 32'd0} || events_o !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL max_freq_set: got %h/%b expected %h/0010", status_o, events_o, {5'b00010, 32'd0});
        end
        holdLevel(1'b0, 30);
        checks++;
        if (status_o !== {5'b00010, 32'd0}) begin
            errors++;
            $display("[TB] FAIL max_freq_held: got %h expected %h", status_o, {5'b00010, 32'd0});
        end
        io_clk_i           = 1'b1;
        clear_violations_i = 1'b1;
        @(negedge sys_clk);
        clear_violations_i = 1'b0;
        checks++;
        if (status_o !== '0) begin
            errors++;
            $display("[TB] FAIL max_freq_clear: got %h expected 0", status_o);
        end
        holdLevel(1'b1, 31);
        holdLevel(1'b0, 32);
        holdLevel(1'b1, 30);
        io_clk_i = 1'b0;
        @(negedge sys_clk);
        clear_violations_i = 1'b1;
        @(negedge sys_clk);
        clear_violations_i = 1'b0;
        checks++;
        if (status_o !== {5'b00010, 32'd0}) begin
            errors++;
            $display("[TB] FAIL clear_vs_set: got %h expected %h", status_o, {5'b00010, 32'd0});
        end
        holdLevel(1'b0, 30);
    endtask

    task automatic test_min_freq();
        io_clk_i           = 1'b1;
        clear_violations_i = 1'b1;
        @(negedge sys_clk);
        clear_violations_i = 1'b0;
        checks++;
        if (status_o !== '0) begin
            errors++;
            $display("[TB] FAIL min_pre_clear: got %h expected 0", status_o);
        end
        holdLevel(1'b1, 31);
        holdLevel(1'b0, 34);
        io_clk_i = 1'b1;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (status_o !== {5'b00100, 32'd0}) begin
            errors++;
            $display("[TB] FAIL min_freq_34: got %h expected %h", status_o, {5'b00100, 32'd0});
        end
        holdLevel(1'b1, 30);
        io_clk_i           = 1'b0;
        clear_violations_i = 1'b1;
        @(negedge sys_clk);
        clear_violations_i = 1'b0;
        holdLevel(1'b0, 32);
        io_clk_i = 1'b1;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (status_o !== '0) begin
            errors++;
            $display("[TB] FAIL phase_33: got %h expected 0", status_o);
        end
        holdLevel(1'b1, 30);
    endtask

    task automatic test_pause();
        holdLevel(1'b0, 32);
        io_clk_i = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            @(negedge sys_clk);
            if (j == 257) begin
                checks++;
                if (status_o !== '0) begin
                    errors++;
                    $display("[TB] FAIL pause_early: got %h expected 0", status_o);
                end
            end else if (j == 258) begin
                checks++;
                if (status_o !== {5'b00001, 32'd4}) begin
                    errors++;
                    $display("[TB] FAIL pause_entry: got %h expected %h", status_o, {5'b00001, 32'd4});
                end
            end else if (j == 321 || j == 322 || j == 385 || j == 386) begin
                checks++;
                if (status_o !== {5'b00001, 32'(4 + (j - 258) / 64)}) begin
                    errors++;
                    $display("[TB] FAIL pause_duration_j%0d: got %h expected %h", j, status_o,
                             {5'b00001, 32'(4 + (j - 258) / 64)});
                end
            end
        end
        io_clk_i = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (status_o !== {5'b00001, 32'd6}) begin
            errors++;
            $display("[TB] FAIL pause_before_exit: got %h expected %h", status_o, {5'b00001, 32'd6});
        end
        @(negedge sys_clk);
        checks++;
        if (status_o !== {5'b00000, 32'd6} || events_o !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL pause_exit: got %h/%b expected %h/0010", status_o, events_o, {5'b00000, 32'd6});
        end
    endtask

    // Each row: pause, then one full period of 2*half, then the recovery flags expected.
    task automatic test_recovery();
        int        halves [3] = '{30, 34, 32};
        logic [4:0] expFlags [3] = '{5'b01000, 5'b10000, 5'b00000};
        logic lvl;
        lvl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clear_violations_i = 1'b1;
            @(negedge sys_clk);
            clear_violations_i = 1'b0;
            repeat (299) @(negedge sys_clk);
            checks++;
            if (status_o !== {5'b00001, 32'd4}) begin
                errors++;
                $display("[TB] FAIL recovery_pause_%0d: got %h expected %h", i, status_o, {5'b00001, 32'd4});
            end
            lvl = ~io_clk_i;
            holdLevel(lvl, halves[i]);
            holdLevel(~lvl, halves[i]);
            io_clk_i = lvl;
            repeat (2) @(negedge sys_clk);
            checks++;
            if (status_o !== {expFlags[i], 32'd4}) begin
                errors++;
                $display("[TB] FAIL recovery_period_%0d: got %h expected %h", 2 * halves[i], status_o, {expFlags[i], 32'd4});
            end
        end
        holdLevel(lvl, 30);
        for (int p = 0; p < 3; p++) begin
            holdLevel(~lvl, 32);
            holdLevel(lvl, 32);
        end
        io_clk_i = ~lvl;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (status_o !== {5'b00000, 32'd4}) begin
            errors++;
            $display("[TB] FAIL steady_after_recovery: got %h expected %h", status_o, {5'b00000, 32'd4});
        end
    endtask

    task automatic test_reset_in_pause();
        repeat (300) @(negedge sys_clk);
        checks++;
        if (status_o !== {5'b00001, 32'd4}) begin
            errors++;
            $display("[TB] FAIL prereset_pause: got %h expected %h", status_o, {5'b00001, 32'd4});
        end
        sys_rst  = 1'b1;
        io_clk_i = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (status_o !== '0 || events_o !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_mid_pause: got %h/%b expected 0/0001", status_o, events_o);
        end
        sys_rst = 1'b0;
        holdLevel(1'b0, 10);
        holdLevel(1'b1, 32);
        io_clk_i = 1'b0;
        repeat (2) @(negedge sys_clk);
        checks++;
        if (status_o !== '0 || events_o !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL first_edge_after_reset: got %h/%b expected 0/0010", status_o, events_o);
        end
    endtask

    initial begin
        $display("[TB] clks_alot_monitor bench starting");
        test_reset();
        test_clock_events();
        test_max_freq();
        test_min_freq();
        test_pause();
        test_recovery();
        test_reset_in_pause();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clks_alot_monitor.md
Name: clks_alot_monitor

Overview:
- Front-end stage of the clks_alot clock-recovery path. It samples the already-synchronised IO clock on the system clock and produces the one-hot `clock_events_s` stream and the `clock_status_s` record consumed by the downstream recovery/deserialiser logic.
- It measures half-periods in sys cycles, flags frequency violations, and detects pauses (and times them in IO cycles). After each pause it checks the first full period.

Parameters:
- COUNTER_WIDTH, 32, width of `pause_duration` and of the internal half-period counter (saturating).
- SYS_CLOCK_MULTIPLE, 64, nominal sys cycles per IO clock period.
- CLOCK_EDGE_UNCERTANTY, 1, allowed +/- sys cycles per half-period. MIN_HALF = SYS_CLOCK_MULTIPLE/2 - U; MAX_HALF = SYS_CLOCK_MULTIPLE/2 + U.
- MINIMUM_MISSED_EDGES_TO_START_PAUSE, 4, IO periods without an edge before a pause is declared. PAUSE_START_LENGTH = this × SYS_CLOCK_MULTIPLE.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- io_clk_i  in  1  IO clock, already synchronised to sys_clk.
- clear_violations_i  in  1  clears the four sticky violation flags.
- events_o  out  4  `clock_events_s`: [3] rising_edge, [2] steady_high, [1] falling_edge, [0] steady_low.
- status_o  out  COUNTER_WIDTH+5  `clock_status_s`:
  - [W+4] recovery_over_violation
  - [W+3] recovery_under_violation
  - [W+2] minimim_frequency_violation
  - [W+1] maximim_frequency_violation
  - [W] pause_active
  - [W-1:0] pause_duration

Behaviour:
- Sampling and edge detection:
  - s1 <= io_clk_i; s2 <= s1.
  - edge = s1 ^ s2. rising = s1 & ~s2; falling = ~s1 & s2.
  - events_o is registered from s1/s2 and is always exactly one-hot. Latency from an io_clk_i change to events_o is 2 cycles.
- Reset: s1 = s2 = 0; events_o = 4'b0001; status_o = 0; half_cnt = 0; FSM = IDLE.
- half_cnt:
  - Loads 1 on an edge; otherwise increments, saturating at 2^W-1.
  - A half-period of N sys cycles therefore reads half_cnt == N on the edge that ends it.
- FSM transitions:
  - IDLE: no frequency checks; first edge -> RUN.
  - RUN: on each edge, half_cnt < MIN_HALF sets maximim_frequency_violation; half_cnt > MAX_HALF sets minimim_frequency_violation.
  - PAUSE: entered from IDLE, RUN or RECOVER when half_cnt == PAUSE_START_LENGTH with no edge that cycle.
    - pause_active = 1 and pause_duration = MINIMUM_MISSED_EDGES_TO_START_PAUSE, both on the following cycle.
    - No frequency violation is flagged for the interval that caused the pause.
    - While in PAUSE, pause_duration increments (saturating) each further SYS_CLOCK_MULTIPLE cycles without an edge.
    - Any edge clears pause_active on the cycle events_o reports that edge, then -> RECOVER.
    - pause_duration holds its value until the next pause entry.
  - RECOVER: half-period checks are suppressed. The block measures the full period P from the pause-ending edge to the next edge of the same polarity.
    - P < 2*MIN_HALF sets recovery_under_violation.
    - P > 2*MAX_HALF sets recovery_over_violation.
    - Then -> RUN.
    - If the pause threshold is reached first, -> PAUSE and no recovery flag is set.
- Sticky flags:
  - The four violation flags stay set until clear_violations_i.
  - If clear and a new set occur in the same cycle, set wins.
- Reset mid-operation (including mid-PAUSE): returns everything to reset values immediately.

Optional Feature:
- CLKS_ALOT_MONITOR_GLITCH_FILTER_EN.
- Defined: s1 only takes a new io_clk_i value after it has been stable for 3 consecutive samples. This filters 1–2 cycle glitches and adds 2 cycles of event latency (total 4). All thresholds are unchanged.
- Undefined: direct two-flop path as described in Behaviour; a single-cycle glitch produces two edges.

Test Plan:
- Defaults (MIN_HALF=31, MAX_HALF=33, PAUSE_START_LENGTH=256). Reset, then 10 periods of 32 high/32 low -> events_o cycles rising/steady_high/falling/steady_low with latency 2; status_o = 0 throughout.
- In RUN, one high phase of 30 cycles -> maximim_frequency_violation = 1 after the ending falling edge and held. Pulse clear_violations_i -> 0 next cycle. Clear coincident with a new 30-cycle phase -> flag stays 1.
- One low phase of 34 cycles -> minimim_frequency_violation = 1. A phase of 33 -> no flag.
- Hold io_clk_i high 400 cycles -> pause_active = 1 one cycle after half_cnt hits 256 (pause_duration 4), 5 at 320, 6 at 384. Falling edge -> pause_active 0, pause_duration stays 6, no frequency flag.
- After a pause, first full period 60 -> recovery_under_violation. Repeat with 68 -> recovery_over_violation. Repeat with 64 -> neither. Subsequent 32/32 -> no flags.
- Assert sys_rst during PAUSE -> next cycle status_o = 0, events_o = 4'b0001, FSM IDLE. The first edge after reset raises no violation.
